// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: address type, header geometry and builder states.
package eth_pkg;

  typedef logic [47:0] mac_addr_t;

  localparam int ETH_HDR_LEN     = 14;
  localparam int ETH_MIN_PAYLOAD = 46;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD
  } builder_state_t;

  // Byte idx of the packed header, byte 0 being the most significant.
  function automatic logic [7:0] hdr_byte(input logic [ETH_HDR_LEN*8-1:0] hdr,
                                          input logic [3:0]               idx);
    hdr_byte = hdr[(ETH_HDR_LEN - 1 - int'(idx)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/eth_frame_builder.sv
// Prepends a fixed Ethernet header to an AXI-Stream payload and zero-pads
// short payloads up to MIN_PAYLOAD bytes. Payload is passed through with no
// buffering, so the output handshake drives the input handshake directly.
module eth_frame_builder
  import eth_pkg::*;
#(
  parameter mac_addr_t   DST_MAC     = 48'hDEADBEEF1234,
  parameter mac_addr_t   SRC_MAC     = 48'h000A35123456,
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
  parameter int          MIN_PAYLOAD = ETH_MIN_PAYLOAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic        in_tlast,
  input  logic [7:0]  in_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output logic [7:0]  out_tdata,
  output logic [15:0] frame_count
);

  // Counter only has to reach MIN_PAYLOAD; keep at least one bit when padding is off.
  localparam int CNT_W = (MIN_PAYLOAD < 1) ? 1 : $clog2(MIN_PAYLOAD + 1);
  localparam logic [31:0] MIN_U = 32'(MIN_PAYLOAD);
  localparam logic [ETH_HDR_LEN*8-1:0] HEADER = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_LEN - 1);

  builder_state_t   state_q, state_d;
  logic [3:0]       hdr_idx_q, hdr_idx_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [15:0]      frame_count_q, frame_count_d;

  logic [31:0]      pay_cnt_ext;
  logic             reaches_min;
  logic [CNT_W-1:0] pay_cnt_sat;

  assign frame_count = frame_count_q;

  // The byte being transferred now completes the minimum payload length.
  // In PAD the same test marks the final pad byte.
  always_comb begin
    pay_cnt_ext = 32'(pay_cnt_q);
    reaches_min = (pay_cnt_ext + 32'd1 >= MIN_U);
    pay_cnt_sat = (pay_cnt_ext < MIN_U) ? pay_cnt_q + CNT_W'(1) : pay_cnt_q;
  end

  // State and counters; everything is control, so all of it is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hdr_idx_q     <= '0;
      pay_cnt_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hdr_idx_q     <= hdr_idx_d;
      pay_cnt_q     <= pay_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state and output decode; outputs are purely a function of state and
  // live handshake inputs, so they read as idle the instant reset asserts.
  always_comb begin
    state_d       = state_q;
    hdr_idx_d     = hdr_idx_q;
    pay_cnt_d     = pay_cnt_q;
    frame_count_d = frame_count_q;
    out_tvalid    = 1'b0;
    out_tdata     = 8'h00;
    out_tlast     = 1'b0;
    in_tready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A pending payload byte only triggers the header; it is not consumed.
        if (in_tvalid) begin
          state_d   = ST_HEADER;
          hdr_idx_d = '0;
          pay_cnt_d = '0;
        end
      end

      ST_HEADER: begin
        out_tvalid = 1'b1;
        out_tdata  = hdr_byte(HEADER, hdr_idx_q);
        if (out_tready) begin
          if (hdr_idx_q == HDR_LAST) begin
            state_d   = ST_PAYLOAD;
            hdr_idx_d = '0;
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        out_tvalid = in_tvalid;
        out_tdata  = in_tdata;
        in_tready  = out_tready;
        out_tlast  = in_tlast && reaches_min;
        if (in_tvalid && out_tready) begin
          pay_cnt_d = pay_cnt_sat;
          if (in_tlast) begin
            if (reaches_min) begin
              state_d       = ST_IDLE;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              state_d = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        out_tvalid = 1'b1;
        out_tlast  = reaches_min;
        if (out_tready) begin
          pay_cnt_d = pay_cnt_sat;
          if (reaches_min) begin
            state_d       = ST_IDLE;
            frame_count_d = frame_count_q + 16'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
